// File: rtl/inst_sequencer.sv
// inst_sequencer: host-loaded program buffer plus issue FSM.
// The host fills the buffer while idle. start_ex then issues the
// instructions in order over a valid/ready handshake. Each instruction
// can carry a stall count (HOLD) and an end-of-program marker (END).
// Completion is signalled by a one-cycle done pulse, and the buffer is
// emptied at the same point.
module inst_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inst_wr,
  input  logic [IW-1:0] inst_in,
  output logic          inst_mem_full,
  output logic [AW:0]   inst_count,
  output logic          wr_drop,
  input  logic          start_ex,
  output logic [IW-1:0] inst_out,
  output logic          inst_valid,
  input  logic          core_ready,
  output logic          busy,
  output logic          done
);

  // Instruction field layout.
  localparam int END_BIT = 16;
  localparam int HOLD_HI = 15;
  localparam int HOLD_LO = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  mem [DEPTH];
  logic [AW:0]    count;
  logic [AW-1:0]  rd;
  logic [3:0]     hold_cnt;

  logic           idle;
  logic           start_ok;
  logic           wr_ok;
  logic           wr_bad;
  logic           last;
  logic           handshake;
  logic [AW-1:0]  rd_nxt;
  logic           cur_end;
  logic [3:0]     cur_hold;

  // Decode of the current request. inst_out always holds the
  // instruction at rd, so its END/HOLD fields steer the FSM directly.
  always_comb begin
    idle      = (state == S_IDLE);
    start_ok  = idle && start_ex && (count != '0);
    // A write that coincides with an accepted start is discarded, so
    // the program length cannot change under the issuer.
    wr_ok     = idle && inst_wr && !start_ok && (count != (AW+1)'(DEPTH));
    wr_bad    = inst_wr && !wr_ok;
    last      = ({1'b0, rd} == (count - (AW+1)'(1)));
    handshake = inst_valid && core_ready;
    rd_nxt    = rd + AW'(1);
    cur_end   = inst_out[END_BIT];
    cur_hold  = inst_out[HOLD_HI:HOLD_LO];
  end

  assign inst_mem_full = (count == (AW+1)'(DEPTH));
  assign inst_count    = count;
  assign busy          = !idle;

  // Program buffer write port. Contents are not reset; count alone
  // defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[AW-1:0]] <= inst_in;
  end

  // Issue FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      rd         <= '0;
      hold_cnt   <= '0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      wr_drop    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (wr_ok) count <= count + (AW+1)'(1);

      // A discarded write wins over the clear from an accepted start,
      // so a write dropped in the start cycle stays visible.
      if (wr_bad)        wr_drop <= 1'b1;
      else if (start_ok) wr_drop <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state      <= S_ISSUE;
            rd         <= '0;
            inst_out   <= mem[0];
            inst_valid <= 1'b1;
          end
        end

        S_ISSUE: begin
          if (handshake) begin
            if (cur_end || last) begin
              // END or the last entry finishes the program; HOLD is ignored.
              state      <= S_DONE;
              inst_valid <= 1'b0;
              done       <= 1'b1;
            end else if (cur_hold == 4'd0) begin
              // Back-to-back issue with no bubble.
              rd       <= rd_nxt;
              inst_out <= mem[rd_nxt];
            end else begin
              state      <= S_HOLD;
              inst_valid <= 1'b0;
              hold_cnt   <= cur_hold;
            end
          end
        end

        S_HOLD: begin
          // hold_cnt == 1 on the last idle cycle. Issuing on that edge
          // leaves exactly HOLD cycles with inst_valid low.
          if (hold_cnt == 4'd1) begin
            state      <= S_ISSUE;
            rd         <= rd_nxt;
            inst_out   <= mem[rd_nxt];
            inst_valid <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

        S_DONE: begin
          // done is high during this cycle. Empty the buffer and return
          // to idle. inst_out keeps the last instruction issued.
          state <= S_IDLE;
          count <= '0;
          rd    <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
